digest_reader: RTL and testbench
================================

// Module: digest_reader
// PURPOSE
//  Unload side of the 128-bit hash state path; the counterpart of the init-hash loader.
//  Captures the final 128-bit hash state from the compression core once per message.
//  Truncates it to the digest length selected by hash variant t.
//  Streams it out MS-word-first as WORD_W-bit words over a valid/ready interface to the host/bus bridge.
// PARAMETERS
//  WORD_W  32  output word width; legal 8, 16, 32 (elaboration $error otherwise)
// PORTS
//  clk           in   1       single clock, all logic rising-edge
//  reset         in   1       synchronous, active-high
//  digest_valid  in   1       core presents final state on digest_in
//  digest_ready  out  1       reader can capture; transfer when valid&&ready
//  digest_in     in   128     final hash state, bit 127 = MSB
//  t             in   2       hash variant, sampled with digest_in on transfer
//  out_valid     out  1       out_data holds a valid digest word
//  out_ready     in   1       sink accepts word; transfer when valid&&ready
//  out_data      out  WORD_W  digest word
//  out_last      out  1       high with the final word of the digest
//  busy          out  1       digest held / streaming in progress
// BEHAVIOUR
//  - Reset values: out_valid=0, out_last=0, out_data=0, busy=0, word count=0, held digest=0.
//  - digest_ready is high after reset.
//  - Digest length DIG_BITS = 128 - 32*t:
//      t=0: 128 bits; t=1: 96; t=2: 64; t=3: 32.
//  - Number of words NW = DIG_BITS/WORD_W. Example at WORD_W=32: NW = 4 - t.
//  - Truncation keeps the most significant DIG_BITS of digest_in.
//  - Word k (k=0..NW-1) = digest_in[127-k*WORD_W -: WORD_W].
//  - FSM IDLE:
//      digest_ready=1.
//      On capture: latch digest_in and NW, clear word count, go to SEND.
//  - FSM SEND:
//      busy=1, out_valid=1.
//      out_data/out_last are registered and stay stable while out_valid && !out_ready.
//      On an out transfer with count < NW-1: count+1, next word presented the next cycle.
//      On an out transfer of word NW-1 (out_last=1): go to IDLE.
//  - Latency: capture in cycle N -> first word valid in cycle N+1.
//    With out_ready held high, one word per cycle; the last word is in cycle N+NW.
//  - Back-to-back: digest_ready = IDLE | (out_valid & out_ready & out_last).
//    A capture in the same cycle as the last-word transfer reloads and stays in SEND.
//    There is no idle bubble. This is a combinational path out_ready -> digest_ready.
//  - digest_valid while not ready: ignored, no state change. The core must hold it.
//  - out_ready high while out_valid low: no effect.
//  - t changes outside a capture cycle have no effect on a digest in flight.
//  - Reset mid-stream:
//      out_valid drops the cycle after reset is sampled.
//      The partial digest is discarded and no out_last is issued.
//      reset has priority over a simultaneous capture.
// CONFIGURATION
//  DIGEST_CLEAR_EN defined:
//   - Held digest register is zeroised on the cycle after the last-word transfer, unless reloaded that cycle.
//   - It is also zeroised on reset.
//   - out_data is forced to 0 whenever out_valid=0.
//  DIGEST_CLEAR_EN undefined:
//   - Held digest retains its value after streaming.
//   - out_data holds the last word presented while idle.
// TESTING
//  1. t=0, digest_in=128'h0123456789ABCDEF_FEDCBA9876543210, out_ready=1
//     -> 4 words 01234567,89ABCDEF,FEDCBA98,76543210 on cycles N+1..N+4; out_last only on 4th.
//  2. t=3, same digest -> 1 word 01234567 with out_last=1; digest_ready high again in N+1.
//  3. t=1, out_ready toggled 1,0,0,1,1
//     -> words 01234567,89ABCDEF,FEDCBA98; data/last stable during stalls; exactly 3 transfers.
//  4. Back-to-back: digest B (t=2) presented during last word of digest A (t=0)
//     -> captured that cycle; B's 2 words follow with no gap.
//  5. Reset asserted after the 2nd of 4 words -> out_valid=0, busy=0 next cycle;
//     no out_last; new capture after reset streams correctly.
//  6. DIGEST_CLEAR_EN: after any digest completes -> internal held digest==0 and out_data==0 while idle.
//     Without the macro -> out_data holds the last word.
//  Also: WORD_W=8, t=2 -> 8 words, MS byte first.

Source files
------------

// File: rtl/digest_reader.sv
// Captures the final 128-bit hash state and streams its truncated digest out MS-word-first.
// Optional DIGEST_CLEAR_EN: zeroise the held digest and idle out_data after each digest.
module digest_reader #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              digest_valid,
  output logic              digest_ready,
  input  logic [127:0]      digest_in,
  input  logic [1:0]        t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);
  localparam int unsigned DIG_W = 128;
  localparam int unsigned WPL   = 32 / WORD_W;  // words per 32-bit truncation step
  localparam int unsigned CNT_W = 5;
  localparam int unsigned IDX_W = 7;

  if (!(WORD_W == 8 || WORD_W == 16 || WORD_W == 32)) begin : g_bad_word_w
    $error("digest_reader: WORD_W must be 8, 16 or 32");
  end

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIG_W-1:0]   r_digest;
  logic [CNT_W-1:0]   r_nw;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_cap;
  logic               w_xfer;
  logic               w_last_xfer;
  logic [CNT_W-1:0]   w_nw_in;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [IDX_W-1:0]   w_base;

  assign w_xfer       = out_valid & out_ready;
  assign w_last_xfer  = w_xfer & out_last;
  // Same-cycle reload on the last word keeps the stream gap-free
  assign digest_ready = (r_state == S_IDLE) | w_last_xfer;
  assign w_cap        = digest_valid & digest_ready;
  assign w_nw_in      = CNT_W'((3'd4 - 3'(t)) * WPL);
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_base       = IDX_W'(DIG_W - 1) - IDX_W'(w_cnt_inc * WORD_W);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cap) w_state_nxt = S_SEND;
      S_SEND:  if (w_last_xfer && !w_cap) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Held digest, word counter and registered stream outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digest  <= '0;
      r_nw      <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else if (w_cap) begin
      r_digest  <= digest_in;
      r_nw      <= w_nw_in;
      r_cnt     <= '0;
      out_valid <= 1'b1;
      busy      <= 1'b1;
      out_data  <= digest_in[DIG_W-1 -: WORD_W];
      out_last  <= (w_nw_in == CNT_W'(1));
    end else if (w_last_xfer) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_last  <= 1'b0;
`ifdef DIGEST_CLEAR_EN
      r_digest  <= '0;
      out_data  <= '0;
`endif
    end else if (w_xfer) begin
      r_cnt    <= w_cnt_inc;
      out_data <= r_digest[w_base -: WORD_W];
      out_last <= (w_cnt_inc == r_nw - CNT_W'(1));
    end
  end

endmodule

// File: tb/tb_digest_reader.sv
// Bench for digest_reader: queue-based word model checked every cycle, directed cases plus random traffic.
`timescale 1ns/1ps
module tb_digest_reader;
  localparam int unsigned W = 32;
  localparam logic [127:0] D0 = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic         clk = 1'b0;
  logic         reset;
  logic         digest_valid, digest_ready, out_valid, out_ready, out_last, busy;
  logic [127:0] digest_in;
  logic [1:0]   t;
  logic [W-1:0] out_data;

  logic         d8_valid, d8_ready, o8_valid, o8_ready, o8_last, busy8;
  logic [127:0] d8_in;
  logic [1:0]   t8;
  logic [7:0]   o8_data;

  digest_reader #(.WORD_W(W)) u_dut (
    .clk(clk), .reset(reset), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .digest_in(digest_in), .t(t), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy));

  digest_reader #(.WORD_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .digest_valid(d8_valid), .digest_ready(d8_ready),
    .digest_in(d8_in), .t(t8), .out_valid(o8_valid), .out_ready(o8_ready),
    .out_data(o8_data), .out_last(o8_last), .busy(busy8));

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; logic last; } exp_t;
  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           xfers = 0;
  bit           mon_en = 1'b0;
  bit           rnd_on = 1'b0;
  logic [W-1:0] last_word = '0;

  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] mword(input logic [127:0] d, input int k);
    logic [127:0] s;
    s = d >> (128 - (k + 1) * W);
    return s[W-1:0];
  endfunction

  function automatic int mnw(input logic [1:0] tt);
    return (128 - 32 * int'(tt)) / W;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a digest is a queue of words; the head is what must be on the bus
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_rdy;
      exp_rdy = (q.size() == 0) || (out_ready && q[0].last);
      chk("out_valid", out_valid, q.size() != 0);
      chk("busy", busy, q.size() != 0);
      chk("digest_ready", digest_ready, exp_rdy);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_last", out_last, q[0].last);
      end else begin
`ifdef DIGEST_CLEAR_EN
        chk("idle_data", out_data, '0);
        chk("held_digest", u_dut.r_digest, '0);
`else
        chk("idle_data", out_data, last_word);
`endif
        chk("idle_last", out_last, 1'b0);
      end
      if (reset) begin
        q.delete();
        last_word = '0;
      end else begin
        if (q.size() != 0 && out_ready) begin
          last_word = q[0].d;
          void'(q.pop_front());
          xfers++;
        end
        if (digest_valid && exp_rdy) begin
          for (int k = 0; k < mnw(t); k++) q.push_back('{mword(digest_in, k), k == mnw(t) - 1});
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [1:0] tt);
    bit done;
    done = 1'b0;
    digest_in = d;
    t = tt;
    digest_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (digest_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    digest_valid = 1'b0;
    chk("send_accepted", done, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int c0, c1, x0;
    logic [4:0]  pat;
    logic [63:0] exp8;
    logic [63:0] sh;
    reset = 1'b1; digest_valid = 1'b0; digest_in = '0; t = '0; out_ready = 1'b0;
    d8_valid = 1'b0; d8_in = '0; t8 = '0; o8_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // Pin the model against hand-computed words
    chk("model_w0", mword(D0, 0), 32'h01234567);
    chk("model_w2", mword(D0, 2), 32'hFEDCBA98);
    chk("model_w3", mword(D0, 3), 32'h76543210);
    chk("model_nw_t1", mnw(2'd1), 3);
    chk("model_nw_t3", mnw(2'd3), 1);

    // Full 128-bit digest, sink always ready
    out_ready = 1'b1;
    send(D0, 2'd0);
    @(negedge clk);
    chk("t1_w0", out_data, 32'h01234567);
    chk("t1_last0", out_last, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_w3", out_data, 32'h76543210);
    chk("t1_last3", out_last, 1'b1);
    @(posedge clk); #1;

    // Single-word digest, ready again in the first word cycle
    send(D0, 2'd3);
    @(negedge clk);
    chk("t2_w0", out_data, 32'h01234567);
    chk("t2_last", out_last, 1'b1);
    chk("t2_rdy", digest_ready, 1'b1);
    @(posedge clk); #1;
    drain();

    // Stalls with out_ready 1,0,0,1,1
    pat = 5'b11001;
    x0 = xfers;
    send(D0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      out_ready = pat[i];
      @(posedge clk); #1;
    end
    chk("t3_xfers", xfers - x0, 3);
    chk("t3_empty", q.size(), 0);

    // Back-to-back: B captured on A's last-word cycle
    out_ready = 1'b1;
    send(D0, 2'd0);
    c0 = cyc;
    send(128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 2'd2);
    c1 = cyc;
    chk("t4_b2b_cycle", c1 - c0, 4);
    drain();

    // Reset after two of four words
    send(D0, 2'd0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    @(posedge clk); #1;
    send(128'h11112222_33334444_55556666_77778888, 2'd1);
    drain();

    // 8-bit words, t=2: eight bytes MS first
    exp8 = 64'h0123456789ABCDEF;
    d8_in = D0; t8 = 2'd2; o8_ready = 1'b1; d8_valid = 1'b1;
    @(negedge clk);
    chk("w8_ready", d8_ready, 1'b1);
    @(posedge clk); #1;
    d8_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sh = exp8 >> (56 - 8 * k);
      chk("w8_valid", o8_valid, 1'b1);
      chk("w8_data", o8_data, sh[7:0]);
      chk("w8_last", o8_last, k == 7);
    end
    @(negedge clk);
    chk("w8_done", o8_valid, 1'b0);
    @(posedge clk); #1;

    // Random traffic with random backpressure and one mid-run reset
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
      begin
        for (int m = 0; m < 60; m++) begin
          repeat ($urandom_range(0, 3)) begin
            t = 2'($urandom);
            @(posedge clk); #1;
          end
          send({$urandom, $urandom, $urandom, $urandom}, 2'($urandom));
          if (m == 30) begin
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
          end
        end
        rnd_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
